// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: fetch PC sequencer feeding a FWFT prefetch FIFO to ID; redirects flush and restart.
// Optional IFETCH_PERF_CNT_EN adds fetch and full-stall counters.
module ifetch_ctrl #(
   parameter int ADDR_W = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   output logic                          imem_ce,
   output logic [ADDR_W-1:0]             imem_addr,
   input  logic [31:0]                   imem_inst,
   output logic                          if_valid,
   output logic [31:0]                   if_inst,
   output logic [ADDR_W-1:0]             if_pc,
   input  logic                          id_ready,
   input  logic                          redirect_valid,
   input  logic [ADDR_W-1:0]             redirect_pc,
   input  logic                          halt,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef IFETCH_PERF_CNT_EN
  ,output logic [31:0]                   perf_fetch_cnt,
   output logic [31:0]                   perf_stall_cnt
`endif
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
   state_t state, state_nx;
   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] mem_pc [FIFO_DEPTH];
   logic [31:0] mem_inst [FIFO_DEPTH];
   logic [AW-1:0] head, tail;
   logic [LW-1:0] level;
   logic pop, fetch;
   always_comb begin
      pop = (level != '0) && id_ready && !redirect_valid;
      fetch = (state == RUN) && !redirect_valid && (level < LW'(FIFO_DEPTH) || pop);
      // redirects outside RUN only flush and reload the PC, the state is held
      state_nx = (redirect_valid && state != RUN) ? state :
                 (state == IDLE) ? RUN : halt ? HALTED : RUN;
   end
   assign imem_ce = fetch;
   assign imem_addr = fetch_pc;
   assign fifo_level = level;
   assign if_valid = level != '0;
   assign if_inst = if_valid ? mem_inst[head] : '0;
   assign if_pc = if_valid ? mem_pc[head] : '0;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         fetch_pc <= RESET_PC;
         head <= '0;
         tail <= '0;
         level <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_pc[i] <= '0;
            mem_inst[i] <= '0;
         end
      end else begin
         state <= state_nx;
         if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~ADDR_W'(3);
            head <= '0;
            tail <= '0;
            level <= '0;
         end else begin
            if (fetch) begin
               mem_pc[tail] <= fetch_pc;
               mem_inst[tail] <= imem_inst;
               tail <= tail + AW'(1);
               fetch_pc <= fetch_pc + ADDR_W'(4);
            end
            if (pop) head <= head + AW'(1);
            level <= level + LW'(fetch) - LW'(pop);
         end
      end
   end
`ifdef IFETCH_PERF_CNT_EN
   logic stall;
   assign stall = (state == RUN) && !redirect_valid && (level == LW'(FIFO_DEPTH)) && !pop;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetch_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (fetch && !(&perf_fetch_cnt)) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         if (stall && !(&perf_stall_cnt)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: scoreboard bench for ifetch_ctrl; expected PCs queued at stimulus, checked on each pop.
module tb_ifetch_ctrl;
   logic clk = 0, rst = 1;
   logic imem_ce, if_valid, id_ready = 0, redirect_valid = 0, halt = 0;
   logic [31:0] imem_addr, imem_inst, if_inst, if_pc, redirect_pc = 0;
   logic [2:0] fifo_level;
`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif
   int errors = 0, checks = 0, pops = 0;
   logic [31:0] sbq [$];
   ifetch_ctrl dut (
      .clk(clk), .rst(rst), .imem_ce(imem_ce), .imem_addr(imem_addr), .imem_inst(imem_inst),
      .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .id_ready(id_ready),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
      .fifo_level(fifo_level)
`ifdef IFETCH_PERF_CNT_EN
     ,.perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
   );
   always #5 clk = ~clk;
   function automatic logic [31:0] rom(input logic [31:0] a);
      return 32'h1000_0000 + {2'b00, a[31:2]};
   endfunction
   assign imem_inst = rom(imem_addr);
   always @(negedge clk) begin
      if (!rst && if_valid && id_ready && !redirect_valid) begin
         logic [31:0] e;
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL pop_unexpected: got pc=%h, required no pop", if_pc);
         end else begin
            e = sbq.pop_front();
            if (if_pc !== e || if_inst !== rom(e)) begin
               errors++;
               $display("FAIL pop_order: got pc=%h inst=%h, required pc=%h inst=%h", if_pc, if_inst, e, rom(e));
            end
         end
         pops++;
      end
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic push_seq(input logic [31:0] start, input int n);
      logic [31:0] p = start;
      for (int i = 0; i < n; i++) begin
         sbq.push_back(p);
         p = p + 32'd4;
      end
   endtask
   task automatic do_reset(input logic rdy);
      rst = 1;
      redirect_valid = 0;
      redirect_pc = 0;
      halt = 0;
      id_ready = rdy;
      #1;
      sbq.delete();
      pops = 0;
      @(posedge clk);
      #1 rst = 0;
   endtask
   task automatic test_reset();
      rst = 1;
      #1;
      checks++;
      if (imem_ce !== 0 || imem_addr !== 0 || if_valid !== 0 || fifo_level !== 0 || if_inst !== 0 || if_pc !== 0) begin
         errors++;
         $display("FAIL reset_vals: ce=%b addr=%h v=%b lvl=%0d inst=%h pc=%h, required all 0", imem_ce, imem_addr, if_valid, fifo_level, if_inst, if_pc);
      end
      do_reset(1);
      push_seq(0, 4);
      checks++;
      if (imem_ce !== 0) begin errors++; $display("FAIL idle_ce: got %b, required 0", imem_ce); end
      step();
      checks++;
      if (imem_ce !== 1 || imem_addr !== 0 || if_valid !== 0) begin
         errors++;
         $display("FAIL first_fetch: ce=%b addr=%h v=%b, required 1 0 0", imem_ce, imem_addr, if_valid);
      end
      step();
      checks++;
      if (if_valid !== 1 || if_pc !== 0 || if_inst !== 32'h1000_0000 || fifo_level !== 1) begin
         errors++;
         $display("FAIL first_valid: v=%b pc=%h inst=%h lvl=%0d, required 1 0 10000000 1", if_valid, if_pc, if_inst, fifo_level);
      end
   endtask
   task automatic test_stream();
      do_reset(1);
      push_seq(0, 40);
      repeat (18) step();
      checks++;
      if (pops !== 16 || if_pc !== 32'd64) begin
         errors++;
         $display("FAIL stream: pops=%0d head=%h, required 16 00000040", pops, if_pc);
      end
   endtask
   task automatic test_full();
      do_reset(0);
      push_seq(0, 40);
      repeat (6) step();
      checks++;
      if (fifo_level !== 4 || imem_ce !== 0 || imem_addr !== 32'd16 || if_pc !== 0) begin
         errors++;
         $display("FAIL full: lvl=%0d ce=%b addr=%h head=%h, required 4 0 00000010 0", fifo_level, imem_ce, imem_addr, if_pc);
      end
      id_ready = 1;
      repeat (5) step();
      checks++;
      if (pops !== 5 || fifo_level !== 4) begin
         errors++;
         $display("FAIL full_drain: pops=%0d lvl=%0d, required 5 4", pops, fifo_level);
      end
   endtask
   task automatic test_redirect();
      do_reset(0);
      repeat (4) step();
      checks++;
      if (fifo_level !== 3) begin errors++; $display("FAIL redir_pre: lvl=%0d, required 3", fifo_level); end
      redirect_valid = 1;
      redirect_pc = 32'h0000_0103;
      step();
      redirect_valid = 0;
      #1;
      checks++;
      if (fifo_level !== 0 || imem_addr !== 32'h100 || if_valid !== 0 || imem_ce !== 1) begin
         errors++;
         $display("FAIL redir_flush: lvl=%0d addr=%h v=%b ce=%b, required 0 00000100 0 1", fifo_level, imem_addr, if_valid, imem_ce);
      end
      id_ready = 1;
      push_seq(32'h100, 20);
      step();
      checks++;
      if (if_valid !== 1 || if_pc !== 32'h100) begin
         errors++;
         $display("FAIL redir_target: v=%b pc=%h, required 1 00000100", if_valid, if_pc);
      end
      repeat (4) step();
      checks++;
      if (pops !== 4 || if_pc !== 32'h110) begin
         errors++;
         $display("FAIL redir_seq: pops=%0d head=%h, required 4 00000110", pops, if_pc);
      end
   endtask
   task automatic test_redirect_pop();
      do_reset(1);
      push_seq(0, 20);
      repeat (3) step();
      redirect_valid = 1;
      redirect_pc = 32'h200;
      step();
      redirect_valid = 0;
      #1;
      checks++;
      if (fifo_level !== 0 || if_valid !== 0 || pops !== 1) begin
         errors++;
         $display("FAIL redir_pop: lvl=%0d v=%b pops=%0d, required 0 0 1", fifo_level, if_valid, pops);
      end
      sbq.delete();
      push_seq(32'h200, 10);
      step();
      checks++;
      if (if_valid !== 1 || if_pc !== 32'h200) begin
         errors++;
         $display("FAIL redir_pop_tgt: v=%b pc=%h, required 1 00000200", if_valid, if_pc);
      end
      repeat (2) step();
      checks++;
      if (pops !== 3) begin errors++; $display("FAIL redir_pop_cnt: pops=%0d, required 3", pops); end
   endtask
   task automatic test_halt();
      do_reset(0);
      push_seq(0, 20);
      repeat (3) step();
      checks++;
      if (fifo_level !== 2) begin errors++; $display("FAIL halt_pre: lvl=%0d, required 2", fifo_level); end
      halt = 1;
      id_ready = 1;
      repeat (5) step();
      checks++;
      if (imem_ce !== 0 || if_valid !== 0 || fifo_level !== 0 || pops !== 3 || imem_addr !== 32'd12) begin
         errors++;
         $display("FAIL halt_drain: ce=%b v=%b lvl=%0d pops=%0d addr=%h, required 0 0 0 3 0000000c", imem_ce, if_valid, fifo_level, pops, imem_addr);
      end
      halt = 0;
      step();
      checks++;
      if (imem_ce !== 1 || imem_addr !== 32'd12) begin
         errors++;
         $display("FAIL halt_resume: ce=%b addr=%h, required 1 0000000c", imem_ce, imem_addr);
      end
      step();
      checks++;
      if (if_valid !== 1 || if_pc !== 32'd12) begin
         errors++;
         $display("FAIL halt_next: v=%b pc=%h, required 1 0000000c", if_valid, if_pc);
      end
   endtask
   task automatic test_wrap();
      do_reset(1);
      push_seq(0, 4);
      repeat (2) step();
      redirect_valid = 1;
      redirect_pc = 32'hFFFF_FFF8;
      step();
      redirect_valid = 0;
      sbq.delete();
      pops = 0;
      push_seq(32'hFFFF_FFF8, 4);
      repeat (4) step();
      checks++;
      if (pops !== 3 || if_pc !== 32'd4) begin
         errors++;
         $display("FAIL wrap: pops=%0d head=%h, required 3 00000004", pops, if_pc);
      end
   endtask
   task automatic test_async_reset();
      do_reset(1);
      push_seq(0, 20);
      repeat (5) step();
      #2 rst = 1;
      #1;
      checks++;
      if (fifo_level !== 0 || if_valid !== 0 || imem_addr !== 0 || imem_ce !== 0) begin
         errors++;
         $display("FAIL async_rst: lvl=%0d v=%b addr=%h ce=%b, required 0 0 0 0", fifo_level, if_valid, imem_addr, imem_ce);
      end
      step();
   endtask
`ifdef IFETCH_PERF_CNT_EN
   task automatic test_perf();
      do_reset(0);
      push_seq(0, 40);
      repeat (8) step();
      id_ready = 1;
      repeat (6) step();
      checks++;
      if (perf_fetch_cnt !== 10 || perf_stall_cnt !== 3) begin
         errors++;
         $display("FAIL perf: fetch=%0d stall=%0d, required 10 3", perf_fetch_cnt, perf_stall_cnt);
      end
   endtask
`endif
   initial begin
      test_reset();
      test_stream();
      test_full();
      test_redirect();
      test_redirect_pop();
      test_halt();
      test_wrap();
      test_async_reset();
`ifdef IFETCH_PERF_CNT_EN
      test_perf();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
